// File: rtl/ysyx_22040895_alu_arb_if.sv
// Request/response/ALU bundle between two requesters, the ALU arbiter and the shared ALU.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface ysyx_22040895_alu_arb_if #(
   parameter int DATA_W = 64,
   parameter int OP_W   = 4
);
   logic              flush_i;

   logic              req0_valid_i;
   logic              req0_ready_o;
   logic [OP_W-1:0]   req0_aluop_i;
   logic [DATA_W-1:0] req0_op1_i;
   logic [DATA_W-1:0] req0_op2_i;
   logic              req1_valid_i;
   logic              req1_ready_o;
   logic [OP_W-1:0]   req1_aluop_i;
   logic [DATA_W-1:0] req1_op1_i;
   logic [DATA_W-1:0] req1_op2_i;

   logic              rsp0_valid_o;
   logic              rsp0_ready_i;
   logic [DATA_W-1:0] rsp0_result_o;
   logic              rsp0_lt_o;
   logic              rsp0_ltu_o;
   logic              rsp0_zero_o;
   logic              rsp1_valid_o;
   logic              rsp1_ready_i;
   logic [DATA_W-1:0] rsp1_result_o;
   logic              rsp1_lt_o;
   logic              rsp1_ltu_o;
   logic              rsp1_zero_o;

   logic [OP_W-1:0]   alu_aluop_o;
   logic [DATA_W-1:0] alu_op1_o;
   logic [DATA_W-1:0] alu_op2_o;
   logic [DATA_W-1:0] alu_result_i;
   logic              alu_lt_i;
   logic              alu_ltu_i;
   logic              alu_zero_i;

   modport slave (
      input  flush_i,
      input  req0_valid_i, req0_aluop_i, req0_op1_i, req0_op2_i,
      output req0_ready_o,
      input  req1_valid_i, req1_aluop_i, req1_op1_i, req1_op2_i,
      output req1_ready_o,
      output rsp0_valid_o, rsp0_result_o, rsp0_lt_o, rsp0_ltu_o, rsp0_zero_o,
      input  rsp0_ready_i,
      output rsp1_valid_o, rsp1_result_o, rsp1_lt_o, rsp1_ltu_o, rsp1_zero_o,
      input  rsp1_ready_i,
      output alu_aluop_o, alu_op1_o, alu_op2_o,
      input  alu_result_i, alu_lt_i, alu_ltu_i, alu_zero_i
   );

   modport master (
      output flush_i,
      output req0_valid_i, req0_aluop_i, req0_op1_i, req0_op2_i,
      input  req0_ready_o,
      output req1_valid_i, req1_aluop_i, req1_op1_i, req1_op2_i,
      input  req1_ready_o,
      input  rsp0_valid_o, rsp0_result_o, rsp0_lt_o, rsp0_ltu_o, rsp0_zero_o,
      output rsp0_ready_i,
      input  rsp1_valid_o, rsp1_result_o, rsp1_lt_o, rsp1_ltu_o, rsp1_zero_o,
      output rsp1_ready_i,
      input  alu_aluop_o, alu_op1_o, alu_op2_o,
      output alu_result_i, alu_lt_i, alu_ltu_i, alu_zero_i
   );
endinterface

// File: rtl/ysyx_22040895_alu_arb.sv
// Round-robin sharing of one combinational ALU between two requesters; result 2 cycles after accept.
// One op in flight; a stalled response blocks new accepts, and req ready never looks at rsp ready.
module ysyx_22040895_alu_arb #(
   parameter int DATA_W = 64,
   parameter int OP_W   = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   ysyx_22040895_alu_arb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state;
   logic              rr;
   logic              gnt;
   logic [OP_W-1:0]   aluop_q;
   logic [DATA_W-1:0] op1_q;
   logic [DATA_W-1:0] op2_q;
   logic [DATA_W-1:0] result_q;
   logic              lt_q;
   logic              ltu_q;
   logic              zero_q;

   logic winner;
   logic accept;
   logic rsp_hs;

   always_comb begin
      winner = rr;
      if (bus.req0_valid_i && !bus.req1_valid_i) begin
         winner = 1'b0;
      end else if (bus.req1_valid_i && !bus.req0_valid_i) begin
         winner = 1'b1;
      end
   end

   // rst_n gates ready so nothing looks accepted while reset is held
   assign bus.req0_ready_o = rst_n & (state == IDLE) & ~bus.flush_i & ~winner;
   assign bus.req1_ready_o = rst_n & (state == IDLE) & ~bus.flush_i &  winner;

   assign accept = (bus.req0_ready_o & bus.req0_valid_i) |
                   (bus.req1_ready_o & bus.req1_valid_i);
   assign rsp_hs = (state == RESP) & (gnt ? bus.rsp1_ready_i : bus.rsp0_ready_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr       <= 1'b0;
         gnt      <= 1'b0;
         aluop_q  <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         result_q <= '0;
         lt_q     <= 1'b0;
         ltu_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else if (bus.flush_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  gnt     <= winner;
                  aluop_q <= winner ? bus.req1_aluop_i : bus.req0_aluop_i;
                  op1_q   <= winner ? bus.req1_op1_i   : bus.req0_op1_i;
                  op2_q   <= winner ? bus.req1_op2_i   : bus.req0_op2_i;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               result_q <= bus.alu_result_i;
               lt_q     <= bus.alu_lt_i;
               ltu_q    <= bus.alu_ltu_i;
               zero_q   <= bus.alu_zero_i;
               state    <= RESP;
            end
            RESP: begin
               if (rsp_hs) begin
                  rr    <= ~gnt;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.alu_aluop_o = aluop_q;
   assign bus.alu_op1_o   = op1_q;
   assign bus.alu_op2_o   = op2_q;

   assign bus.rsp0_valid_o  = (state == RESP) & ~gnt;
   assign bus.rsp1_valid_o  = (state == RESP) &  gnt;
   assign bus.rsp0_result_o = result_q;
   assign bus.rsp1_result_o = result_q;
   assign bus.rsp0_lt_o     = lt_q;
   assign bus.rsp1_lt_o     = lt_q;
   assign bus.rsp0_ltu_o    = ltu_q;
   assign bus.rsp1_ltu_o    = ltu_q;
   assign bus.rsp0_zero_o   = zero_q;
   assign bus.rsp1_zero_o   = zero_q;
endmodule

// File: tb/tb_ysyx_22040895_alu_arb.sv
// Bench for the two-port ALU arbiter: directed vectors, protocol corner cases and a random run.
module tb_ysyx_22040895_alu_arb;
   localparam int DW = 64;
   localparam int OW = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ysyx_22040895_alu_arb_if #(.DATA_W(DW), .OP_W(OW)) bus ();
   ysyx_22040895_alu_arb #(.DATA_W(DW), .OP_W(OW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic [63:0] res;
      logic        lt;
      logic        ltu;
      logic        zero;
   } alu_out_t;

   // Stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, others give 0
   function automatic alu_out_t alu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      alu_out_t o;
      case (op)
         4'd0:    o.res = a + b;
         4'd1:    o.res = a - b;
         4'd2:    o.res = a & b;
         4'd3:    o.res = a | b;
         4'd4:    o.res = a ^ b;
         4'd5:    o.res = {63'd0, $signed(a) < $signed(b)};
         4'd6:    o.res = {63'd0, a < b};
         default: o.res = 64'd0;
      endcase
      o.lt   = $signed(a) < $signed(b);
      o.ltu  = a < b;
      o.zero = (o.res == 64'd0);
      return o;
   endfunction

   alu_out_t alu_o;
   assign alu_o            = alu_ref(bus.alu_aluop_o, bus.alu_op1_o, bus.alu_op2_o);
   assign bus.alu_result_i = alu_o.res;
   assign bus.alu_lt_i     = alu_o.lt;
   assign bus.alu_ltu_i    = alu_o.ltu;
   assign bus.alu_zero_i   = alu_o.zero;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.flush_i      = 1'b0;
      bus.req0_valid_i = 1'b0; bus.req0_aluop_i = '0; bus.req0_op1_i = '0; bus.req0_op2_i = '0;
      bus.req1_valid_i = 1'b0; bus.req1_aluop_i = '0; bus.req1_op1_i = '0; bus.req1_op2_i = '0;
      bus.rsp0_ready_i = 1'b0;
      bus.rsp1_ready_i = 1'b0;
   endtask

   task automatic set_req(input int p, input logic v, input logic [3:0] op,
                          input logic [63:0] a, input logic [63:0] b);
      if (p == 0) begin
         bus.req0_valid_i = v; bus.req0_aluop_i = op; bus.req0_op1_i = a; bus.req0_op2_i = b;
      end else begin
         bus.req1_valid_i = v; bus.req1_aluop_i = op; bus.req1_op1_i = a; bus.req1_op2_i = b;
      end
   endtask

   task automatic set_rsp_ready(input int p, input logic r);
      if (p == 0) bus.rsp0_ready_i = r;
      else        bus.rsp1_ready_i = r;
   endtask

   function automatic logic rdy(input int p);
      return (p == 0) ? bus.req0_ready_o : bus.req1_ready_o;
   endfunction

   function automatic logic rvld(input int p);
      return (p == 0) ? bus.rsp0_valid_o : bus.rsp1_valid_o;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   typedef struct {
      int          port;
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        lt;
      logic        ltu;
      logic        zero;
   } vec_t;

   vec_t vt[8];

   bit       busy;
   int       age;
   bit       rr_m;
   bit       port_m;
   bit       win;
   bit       e_rdy0, e_rdy1, e_rv;
   alu_out_t exp_o;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{0, 4'd0, 64'd5,               64'd3,                  64'd8,      1'b0, 1'b0, 1'b0};
      vt[1] = '{1, 4'd1, 64'd7,               64'd7,                  64'd0,      1'b0, 1'b0, 1'b1};
      vt[2] = '{0, 4'd3, 64'hF0,              64'h0F,                 64'hFF,     1'b0, 1'b0, 1'b0};
      vt[3] = '{1, 4'd6, 64'd1,               64'hFFFF_FFFF_FFFF_FFFF, 64'd1,     1'b0, 1'b1, 1'b0};
      vt[4] = '{0, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,             64'd1,      1'b1, 1'b0, 1'b0};
      vt[5] = '{1, 4'd15, 64'd5,              64'd5,                  64'd0,      1'b0, 1'b0, 1'b1};
      vt[6] = '{0, 4'd4, 64'hAAAA,            64'hAAAA,               64'd0,      1'b0, 1'b0, 1'b1};
      vt[7] = '{1, 4'd2, 64'hFF00,            64'h0FF0,               64'h0F00,   1'b0, 1'b0, 1'b0};

      // Reset holds everything low, even ready with a valid request waiting
      idle_inputs();
      rst_n = 1'b0;
      bus.req0_valid_i = 1'b1;
      #3;
      chk("reset req0_ready", bus.req0_ready_o, 0);
      chk("reset rsp0_valid", bus.rsp0_valid_o, 0);
      chk("reset rsp1_valid", bus.rsp1_valid_o, 0);
      chk("reset result", bus.rsp0_result_o, 0);
      chk("reset alu_op1", bus.alu_op1_o, 0);
      step();
      rst_n = 1'b1;
      #1;
      chk("post-reset req0_ready", bus.req0_ready_o, 1);
      bus.req0_valid_i = 1'b0;

      // Directed vectors, one request at a time
      for (int i = 0; i < 8; i++) begin
         step();
         idle_inputs();
         set_req(vt[i].port, 1'b1, vt[i].op, vt[i].a, vt[i].b);
         #1;
         chk("vec ready", rdy(vt[i].port), 1);
         chk("vec other ready", rdy(1 - vt[i].port), 0);
         step();
         set_req(vt[i].port, 1'b0, 4'd0, 64'd0, 64'd0);
         #1;
         chk("vec exec alu_op1", bus.alu_op1_o, vt[i].a);
         chk("vec exec alu_op2", bus.alu_op2_o, vt[i].b);
         chk("vec exec alu_aluop", bus.alu_aluop_o, vt[i].op);
         chk("vec exec rsp_valid", rvld(vt[i].port), 0);
         step();
         #1;
         chk("vec rsp_valid", rvld(vt[i].port), 1);
         chk("vec other rsp_valid", rvld(1 - vt[i].port), 0);
         chk("vec result", (vt[i].port == 0) ? bus.rsp0_result_o : bus.rsp1_result_o, vt[i].res);
         chk("vec lt",   (vt[i].port == 0) ? bus.rsp0_lt_o   : bus.rsp1_lt_o,   vt[i].lt);
         chk("vec ltu",  (vt[i].port == 0) ? bus.rsp0_ltu_o  : bus.rsp1_ltu_o,  vt[i].ltu);
         chk("vec zero", (vt[i].port == 0) ? bus.rsp0_zero_o : bus.rsp1_zero_o, vt[i].zero);
         set_rsp_ready(vt[i].port, 1'b1);
         step();
         set_rsp_ready(vt[i].port, 1'b0);
         #1;
         chk("vec rsp dropped", rvld(vt[i].port), 0);
      end

      // Simultaneous requests after reset, then rr alternation on ties
      step();
      idle_inputs();
      do_reset();
      set_req(0, 1'b1, 4'd1, 64'd7, 64'd7);
      set_req(1, 1'b1, 4'd3, 64'hF0, 64'h0F);
      #1;
      chk("tie0 req0_ready", bus.req0_ready_o, 1);
      chk("tie0 req1_ready", bus.req1_ready_o, 0);
      step();
      set_req(0, 1'b0, 4'd0, 64'd0, 64'd0);
      #1;
      chk("tie0 exec req1_ready", bus.req1_ready_o, 0);
      step();
      #1;
      chk("tie0 rsp0_valid", bus.rsp0_valid_o, 1);
      chk("tie0 rsp0 result", bus.rsp0_result_o, 0);
      chk("tie0 rsp0 zero", bus.rsp0_zero_o, 1);
      chk("tie0 rsp1_valid", bus.rsp1_valid_o, 0);
      chk("tie0 resp req1_ready", bus.req1_ready_o, 0);
      bus.rsp0_ready_i = 1'b1;
      step();
      bus.rsp0_ready_i = 1'b0;
      #1;
      chk("tie0 req1 accepted next", bus.req1_ready_o, 1);
      step();
      set_req(1, 1'b0, 4'd0, 64'd0, 64'd0);
      step();
      #1;
      chk("tie0 rsp1_valid", bus.rsp1_valid_o, 1);
      chk("tie0 rsp1 result", bus.rsp1_result_o, 64'hFF);
      bus.rsp1_ready_i = 1'b1;
      step();
      bus.rsp1_ready_i = 1'b0;
      set_req(0, 1'b1, 4'd0, 64'd1, 64'd2);
      set_req(1, 1'b1, 4'd0, 64'd3, 64'd4);
      #1;
      chk("tie1 req0_ready", bus.req0_ready_o, 1);
      chk("tie1 req1_ready", bus.req1_ready_o, 0);
      step();
      set_req(0, 1'b0, 4'd0, 64'd0, 64'd0);
      step();
      #1;
      chk("tie1 rsp0 result", bus.rsp0_result_o, 64'd3);
      bus.rsp0_ready_i = 1'b1;
      step();
      bus.rsp0_ready_i = 1'b0;
      set_req(0, 1'b1, 4'd0, 64'd1, 64'd2);
      #1;
      chk("tie2 req1_ready", bus.req1_ready_o, 1);
      chk("tie2 req0_ready", bus.req0_ready_o, 0);
      step();
      idle_inputs();
      step();
      #1;
      chk("tie2 rsp1 result", bus.rsp1_result_o, 64'd7);
      bus.rsp1_ready_i = 1'b1;
      step();
      bus.rsp1_ready_i = 1'b0;

      // Back-pressure on port 1 while port 0 keeps asking
      set_req(1, 1'b1, 4'd6, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      #1;
      chk("bp req1_ready", bus.req1_ready_o, 1);
      step();
      set_req(1, 1'b0, 4'd0, 64'd0, 64'd0);
      set_req(0, 1'b1, 4'd0, 64'd9, 64'd9);
      #1;
      chk("bp exec req0_ready", bus.req0_ready_o, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         #1;
         chk("bp rsp1_valid", bus.rsp1_valid_o, 1);
         chk("bp rsp1 result", bus.rsp1_result_o, 64'd1);
         chk("bp rsp1 ltu", bus.rsp1_ltu_o, 1);
         chk("bp req0_ready", bus.req0_ready_o, 0);
      end
      bus.rsp1_ready_i = 1'b1;
      step();
      bus.rsp1_ready_i = 1'b0;
      #1;
      chk("bp req0 accepted after stall", bus.req0_ready_o, 1);
      step();
      set_req(0, 1'b0, 4'd0, 64'd0, 64'd0);
      step();
      #1;
      chk("bp rsp0 result", bus.rsp0_result_o, 64'd18);
      bus.rsp0_ready_i = 1'b1;
      step();
      idle_inputs();

      // Flush during EXEC, under IDLE, and during RESP
      do_reset();
      set_req(0, 1'b1, 4'd0, 64'd1, 64'd1);
      #1;
      chk("fl req0_ready", bus.req0_ready_o, 1);
      step();
      set_req(0, 1'b0, 4'd0, 64'd0, 64'd0);
      bus.flush_i = 1'b1;
      #1;
      chk("fl exec rsp0_valid", bus.rsp0_valid_o, 0);
      step();
      set_req(0, 1'b1, 4'd0, 64'd2, 64'd2);
      set_req(1, 1'b1, 4'd0, 64'd4, 64'd4);
      #1;
      chk("fl idle-flush req0_ready", bus.req0_ready_o, 0);
      chk("fl idle-flush req1_ready", bus.req1_ready_o, 0);
      chk("fl rsp0_valid", bus.rsp0_valid_o, 0);
      chk("fl rsp1_valid", bus.rsp1_valid_o, 0);
      bus.flush_i = 1'b0;
      #1;
      chk("fl rr kept req0_ready", bus.req0_ready_o, 1);
      chk("fl rr kept req1_ready", bus.req1_ready_o, 0);
      step();
      set_req(0, 1'b0, 4'd0, 64'd0, 64'd0);
      set_req(1, 1'b0, 4'd0, 64'd0, 64'd0);
      step();
      #1;
      chk("fl resp rsp0_valid", bus.rsp0_valid_o, 1);
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      set_req(0, 1'b1, 4'd0, 64'd2, 64'd2);
      set_req(1, 1'b1, 4'd0, 64'd4, 64'd4);
      #1;
      chk("fl resp dropped", bus.rsp0_valid_o, 0);
      chk("fl resp rr kept", bus.req0_ready_o, 1);
      idle_inputs();

      // Async reset while a response is waiting
      step();
      set_req(1, 1'b1, 4'd6, 64'd1, 64'd2);
      step();
      set_req(1, 1'b0, 4'd0, 64'd0, 64'd0);
      step();
      #1;
      chk("ar pre rsp1_valid", bus.rsp1_valid_o, 1);
      chk("ar pre rsp1 lt", bus.rsp1_lt_o, 1);
      rst_n = 1'b0;
      #1;
      chk("ar rsp1_valid", bus.rsp1_valid_o, 0);
      chk("ar result", bus.rsp1_result_o, 0);
      chk("ar lt", bus.rsp1_lt_o, 0);
      chk("ar ltu", bus.rsp1_ltu_o, 0);
      chk("ar alu_op2", bus.alu_op2_o, 0);
      chk("ar alu_aluop", bus.alu_aluop_o, 0);
      #2;
      rst_n = 1'b1;
      set_req(0, 1'b1, 4'd0, 64'd0, 64'd0);
      set_req(1, 1'b1, 4'd0, 64'd0, 64'd0);
      #1;
      chk("ar tie req0_ready", bus.req0_ready_o, 1);
      chk("ar tie req1_ready", bus.req1_ready_o, 0);
      idle_inputs();

      // Random traffic against a transaction-level model
      step();
      do_reset();
      busy = 0; age = 0; rr_m = 0; port_m = 0;
      for (int c = 0; c < 500; c++) begin
         step();
         bus.req0_valid_i = ($urandom_range(0, 3) != 0);
         bus.req1_valid_i = ($urandom_range(0, 3) != 0);
         bus.req0_aluop_i = 4'($urandom_range(0, 7));
         bus.req1_aluop_i = 4'($urandom_range(0, 7));
         bus.req0_op1_i   = {$urandom, $urandom};
         bus.req1_op1_i   = {$urandom, $urandom};
         bus.req0_op2_i   = ($urandom_range(0, 3) == 0) ? bus.req0_op1_i : {$urandom, $urandom};
         bus.req1_op2_i   = ($urandom_range(0, 3) == 0) ? bus.req1_op1_i : {$urandom, $urandom};
         bus.rsp0_ready_i = $urandom_range(0, 1) == 1;
         bus.rsp1_ready_i = $urandom_range(0, 1) == 1;
         bus.flush_i      = ($urandom_range(0, 19) == 0);
         #1;
         // A tie goes to the rr port, otherwise to whichever port is asking
         if (bus.req0_valid_i && bus.req1_valid_i) win = rr_m;
         else if (bus.req0_valid_i || bus.req1_valid_i) win = bus.req1_valid_i;
         else win = rr_m;
         e_rdy0 = !busy && !bus.flush_i && !win;
         e_rdy1 = !busy && !bus.flush_i && win;
         e_rv   = busy && (age == 2);
         chk("rnd req0_ready", bus.req0_ready_o, e_rdy0);
         chk("rnd req1_ready", bus.req1_ready_o, e_rdy1);
         chk("rnd rsp0_valid", bus.rsp0_valid_o, e_rv && !port_m);
         chk("rnd rsp1_valid", bus.rsp1_valid_o, e_rv && port_m);
         if (e_rv) begin
            chk("rnd result", port_m ? bus.rsp1_result_o : bus.rsp0_result_o, exp_o.res);
            chk("rnd flags", port_m ? {bus.rsp1_lt_o, bus.rsp1_ltu_o, bus.rsp1_zero_o}
                                    : {bus.rsp0_lt_o, bus.rsp0_ltu_o, bus.rsp0_zero_o},
                {exp_o.lt, exp_o.ltu, exp_o.zero});
         end
         if (bus.flush_i) begin
            busy = 0;
         end else if (busy) begin
            if (age == 2 && (port_m ? bus.rsp1_ready_i : bus.rsp0_ready_i)) begin
               busy = 0;
               rr_m = !port_m;
            end else if (age < 2) begin
               age++;
            end
         end else if ((bus.req0_valid_i && e_rdy0) || (bus.req1_valid_i && e_rdy1)) begin
            busy   = 1;
            age    = 1;
            port_m = win;
            exp_o  = win ? alu_ref(bus.req1_aluop_i, bus.req1_op1_i, bus.req1_op2_i)
                         : alu_ref(bus.req0_aluop_i, bus.req0_op1_i, bus.req0_op2_i);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
